// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed common-anode 7-segment scan driver.
// Latches display data once per frame; supports per-digit blink and dp, plus a blanking gap at each slot start.
module seg_scan_driver #(
  parameter int SCAN_CNT  = 50_000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_CNT = 12_500_000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Disp_Data,
  input  logic [7:0]  Dp,
  input  logic [7:0]  Blink,
  input  logic        Disp_En,
  output logic [7:0]  SEL,
  output logic [7:0]  SEG,
  output logic        Frame_Start
);

  localparam int SW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_CNT - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic [2:0]    digit_q, digit_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    dp_q, dp_d;
  logic [7:0]    blink_q, blink_d;
  logic [7:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic          fs_q, fs_d;

  logic          slot_wrap;
  logic          frame_begin;
  logic          blank;
  logic [3:0]    nibble;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h3F;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  always_comb begin
    slot_wrap   = (slot_q == SLOT_LAST);
    slot_d      = slot_wrap ? '0 : slot_q + SW'(1);
    digit_d     = slot_wrap ? digit_q + 3'd1 : digit_q;

    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + BW'(1);
    blink_ph_d  = (blink_cnt_q == BLINK_LAST) ? ~blink_ph_q : blink_ph_q;

    // Counter state (0,0) marks the first cycle of a frame, including the first cycle out of reset.
    frame_begin = (slot_q == '0) && (digit_q == 3'd0);
    data_d      = frame_begin ? Disp_Data : data_q;
    dp_d        = frame_begin ? Dp        : dp_q;
    blink_d     = frame_begin ? Blink     : blink_q;
    fs_d        = frame_begin;

    nibble      = data_d[{digit_q, 2'b00} +: 4];
    blank       = (slot_q < BLANK_END) || !Disp_En || (blink_d[digit_q] && blink_ph_q);

    sel_d = 8'hFF;
    seg_d = 8'hFF;
    if (!blank) begin
      sel_d = ~(8'b1 << digit_q);
      seg_d = {~dp_d[digit_q], decode(nibble)};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      slot_q      <= '0;
      digit_q     <= 3'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      data_q      <= '0;
      dp_q        <= '0;
      blink_q     <= '0;
      sel_q       <= 8'hFF;
      seg_q       <= 8'hFF;
      fs_q        <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      data_q      <= data_d;
      dp_q        <= dp_d;
      blink_q     <= blink_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      fs_q        <= fs_d;
    end
  end

  assign SEL         = sel_q;
  assign SEG         = seg_q;
  assign Frame_Start = fs_q;

endmodule
